// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-controller / block-memory link.
// Both sides import this so widths and state encodings stay in step.
package mem_if_pkg;

  localparam int BLOCK_ADDR_W = 6;
  localparam int BLOCK_DATA_W = 32;
  localparam int NUM_BLOCKS   = 64;
  localparam int CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } mem_op_t;

endpackage

// File: rtl/block_data_memory_if.sv
// Request/response bus between the cache controller (master) and the block memory (slave).
interface block_data_memory_if;
  import mem_if_pkg::*;

  logic                    read;
  logic                    write;
  logic [BLOCK_ADDR_W-1:0] address;
  logic [BLOCK_DATA_W-1:0] writedata;
  logic [BLOCK_DATA_W-1:0] readdata;
  logic                    busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );

endinterface

// File: rtl/access_latency_counter.sv
// Loadable down-counter that paces a memory access; zero marks the completion edge.
module access_latency_counter
  import mem_if_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// Multi-cycle 32-bit block memory: captures one request, holds busywait for
// ACCESS_CYCLES edges, then commits the write or updates readdata.
module block_data_memory #(
  parameter int ACCESS_CYCLES = 5,
  parameter int NUM_BLOCKS    = mem_if_pkg::NUM_BLOCKS
) (
  input logic                clock,
  input logic                reset,
  block_data_memory_if.slave bus
);
  import mem_if_pkg::*;

  localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(ACCESS_CYCLES - 1);

  mem_state_t              state;
  mem_state_t              next_state;
  mem_op_t                 op_q;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic [BLOCK_DATA_W-1:0] data_q;
  logic [BLOCK_DATA_W-1:0] mem [NUM_BLOCKS];
  logic [CNT_W-1:0]        count;
  logic                    zero;
  logic                    valid;
  logic                    load;
  logic                    dec;
  logic                    complete;

  // read and write together is treated as no request at all
  assign valid = reset && (bus.read ^ bus.write);

  access_latency_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .dec        (dec),
    .load_value (LOAD_VALUE),
    .count      (count),
    .zero       (zero)
  );

  always_comb begin
    next_state   = state;
    load         = 1'b0;
    dec          = 1'b0;
    complete     = 1'b0;
    bus.busywait = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          bus.busywait = 1'b1;
          load         = 1'b1;
          next_state   = BUSY;
        end
      end
      BUSY: begin
        bus.busywait = 1'b1;
        if (zero) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= OP_WRITE;
      bus.readdata <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        addr_q <= bus.address;
        data_q <= bus.writedata;
        op_q   <= bus.read ? OP_READ : OP_WRITE;
      end
      if (complete && (op_q == OP_READ)) begin
        bus.readdata <= mem[addr_q];
      end
    end
  end

  // The array has no reset so its contents survive a reset pulse
  always_ff @(posedge clock) begin
    if (complete && (op_q == OP_WRITE)) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 5, number of posedges from capture to completion (legal 1..15).
REQ-002 SHALL have parameter NUM_BLOCKS, default 64, number of 32-bit blocks (address space 2^6).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port read  input  1  block read request from the cache controller.
REQ-006 SHALL have port write  input  1  block write-back request from the cache controller.
REQ-007 SHALL have port address  input  6  block address ({tag,index} of the cache).
REQ-008 SHALL have port writedata  input  32  block to write; byte 0 in [7:0].
REQ-009 SHALL have port readdata  output  32  block read result; byte 0 in [7:0].
REQ-010 SHALL have port busywait  output  1  high while a request is pending or in progress.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY, plus a 4-bit down-counter.
REQ-012 A request SHALL be valid when exactly one of read/write is high; read&&write high together SHALL be ignored (no access, busywait low).
REQ-013 busywait SHALL be combinational: (IDLE && valid request) || BUSY, so it rises in the same cycle a request appears.
REQ-014 On a posedge in IDLE with a valid request: latch address, writedata, and op; load counter with ACCESS_CYCLES-1; enter BUSY (capture edge E0).
REQ-015 In BUSY, each posedge with counter != 0 SHALL decrement the counter; address/writedata/read/write changes SHALL be ignored.
REQ-016 At the posedge in BUSY with counter == 0 (edge E_ACCESS_CYCLES): a read SHALL load readdata from the latched block; a write SHALL store the latched writedata; then return to IDLE.
REQ-017 After the completion edge, busywait SHALL be low unless a new valid request is present, which is then captured at the next posedge (no back-to-back capture on the completion edge).
REQ-018 readdata SHALL hold its value until the next read completes; writes SHALL not alter readdata.
REQ-019 If the request drops while in BUSY, the access SHALL still complete (write committed, readdata updated).
REQ-020 Whole-block access only; no byte enables; the address SHALL index blocks 0..NUM_BLOCKS-1 with no wrap logic beyond 6-bit width.

Reset
REQ-021 While reset==0: state IDLE, counter 0, readdata 32'h0, busywait 0, latched registers cleared.
REQ-022 Reset asserted mid-access SHALL abort it: no array write occurs and readdata is not updated.
REQ-023 Memory array contents SHALL not be altered by reset (preserved across reset; undefined at power-up).

Structure
REQ-024 A shared package/defines file (mem_if_pkg) SHALL hold BLOCK_ADDR_W=6, BLOCK_DATA_W=32, NUM_BLOCKS=64, and the IDLE/BUSY state encodings, used by both the cache controller and this block.
REQ-025 The latency counter SHALL be a sub-module, access_latency_counter (load, decrement, zero flag, async active-low reset).

Verification
REQ-026 Write 32'hDEADBEEF to block 6'h05, then read 6'h05 (ACCESS_CYCLES=5) -> each busywait pulse lasts request cycle + 5 edges; readdata=32'hDEADBEEF after the 5th edge.
REQ-027 Read asserted with read and write both high for 3 cycles -> busywait stays 0; no array change; readdata unchanged.
REQ-028 Start a read of 6'h3F, change address to 6'h00 at E2 -> readdata returns block 6'h3F contents at E5.
REQ-029 Write 32'h12345678 to 6'h0A, pulse reset low at E3 -> busywait 0 immediately; a later read of 6'h0A returns the prior contents, not 32'h12345678.
REQ-030 Write then read back blocks 6'h00 and 6'h3F with distinct values, with ACCESS_CYCLES=1 and 15 -> correct data, busywait lengths 1+1 and 1+15 cycles.
REQ-031 Drop the write request at E1 -> the write still commits at E_ACCESS_CYCLES (verified by a subsequent read).
